// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU control codes and
// architectural register index constants.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // ALU control encodings shared by the ALU and the ALU control unit.
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  // Architectural register indices with a fixed meaning.
  localparam int unsigned X0 = 0;

endpackage

// File: rtl/regfile_if.sv
// Register file bus: one write port, two operand read ports and a debug
// read port. The core drives it through master, the register file through slave.
interface regfile_if #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int AW   = riscv_pkg::REG_ADDR_W
);

  logic            RegWrite;
  logic [AW-1:0]   WriteReg;
  logic [XLEN-1:0] WriteData;
  logic [AW-1:0]   ReadReg1;
  logic [AW-1:0]   ReadReg2;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic [AW-1:0]   DbgReg;
  logic [XLEN-1:0] DbgData;

  modport master (
    output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
    input  ReadData1, ReadData2, DbgData
  );

  modport slave (
    input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
    output ReadData1, ReadData2, DbgData
  );

endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: selects an entry, forces x0 to zero and
// optionally forwards the in-flight write value when the indices match.
module regfile_rdport #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]   idx,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic            byp_en,
  input  logic [AW-1:0]   byp_idx,
  input  logic [XLEN-1:0] byp_data,
  output logic [XLEN-1:0] data
);
  import riscv_pkg::*;

  // Read mux: x0 first, then the forwarded write, then committed storage.
  always_comb begin
    // NOTE: a default assignment up front keeps every path driven, so no latch is inferred.
    data = regs[idx];
    if (idx == AW'(X0)) begin
      data = '0;
    end else if (byp_en && (byp_idx == idx)) begin
      data = byp_data;
    end
  end

endmodule

// File: rtl/regfile.sv
// Integer register file for the RV32 single-cycle core: two combinational
// read ports, one synchronous write port, x0 hardwired to zero, optional
// write-to-read bypass and a committed-state debug read port.
module regfile #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = 2 ** riscv_pkg::REG_ADDR_W,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  bus
);
  import riscv_pkg::*;

  // Entry 0 has no flops; only x1..x(NREGS-1) are storage.
  logic [XLEN-1:0] regq [1:NREGS-1];
  logic [XLEN-1:0] view [NREGS];
  logic            wr_en;
  logic            byp_en;

  // A write commits only outside reset and never to x0; the same qualifier
  // gates the bypass so reset also disables forwarding.
  assign wr_en  = bus.RegWrite && !reset && (bus.WriteReg != AW'(X0));
  assign byp_en = BYPASS && wr_en;

  // Storage update: asynchronous clear, then at most one entry per edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is reset here because architectural state must read 0 after reset; plain RAMs would not be.
      for (int i = 1; i < NREGS; i++) regq[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        // NOTE: non-blocking assignment so every reader in this edge sees pre-edge state.
        if (wr_en && (bus.WriteReg == AW'(i))) regq[i] <= bus.WriteData;
      end
    end
  end

  // Full-width view of the register file with a constant zero in slot 0.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < NREGS; i++) view[i] = regq[i];
  end

  regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rd1 (
    .idx      (bus.ReadReg1),
    .regs     (view),
    .byp_en   (byp_en),
    .byp_idx  (bus.WriteReg),
    .byp_data (bus.WriteData),
    .data     (bus.ReadData1)
  );

  regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rd2 (
    .idx      (bus.ReadReg2),
    .regs     (view),
    .byp_en   (byp_en),
    .byp_idx  (bus.WriteReg),
    .byp_data (bus.WriteData),
    .data     (bus.ReadData2)
  );

  // Debug port shows committed state only, so its forwarding path is tied off.
  regfile_rdport #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_dbg (
    .idx      (bus.DbgReg),
    .regs     (view),
    .byp_en   (1'b0),
    .byp_idx  ('0),
    .byp_data ('0),
    .data     (bus.DbgData)
  );

endmodule
